pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Consumer side of the load-use hazard interface. Takes the registered bubble_enable from the hazard unit, plus branch/jump redirects from the ALU stage and busywaits from both memories.
- Produces the per-stage write-enable, bubble and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB in the 5-stage RISC-V pipeline.
- Guarantees exactly one bubble per load-use event, including when the event coincides with a memory freeze.
- Keeps saturating performance counters.

Parameters:
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  pipeline clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
bubble_enable  input  1  load-use bubble request; registered level from the hazard unit.
branch_taken  input  1  ALU-stage redirect (taken branch or jump) this cycle.
imem_busywait  input  1  instruction memory not ready.
dmem_busywait  input  1  data memory not ready.
counter_clear  input  1  synchronous clear of all counters.
pc_write_en  output  1  PC may update.
if_id_write_en  output  1  IF/ID may latch.
if_id_flush  output  1  IF/ID loads NOP.
id_ex_bubble  output  1  ID/EX loads NOP (load-use bubble).
id_ex_flush  output  1  ID/EX loads NOP (redirect).
ex_mem_write_en  output  1  EX/MEM may latch.
mem_wb_write_en  output  1  MEM/WB may latch.
stall_cycles  output  CNT_W  cycles with pc_write_en low.
bubble_count  output  CNT_W  bubbles inserted.
flush_count  output  CNT_W  redirects applied.

Behaviour:
- Control outputs are combinational from state, pending_bubble and inputs, so they act in the same cycle. Counters and state are registered.
- Reset (async, any time, including mid-freeze):
  - state=RUN, pending_bubble=0, counters=0.
  - While reset is high: all write enables 1, all flush/bubble outputs 0.
- States:
  - RUN: normal operation.
  - FREEZE: dmem_busywait was seen.
  - BUBBLE_GUARD: one cycle after a bubble.
  - FLUSH_GUARD: one cycle after a redirect.
- Priority each cycle (highest first):
  1. dmem_busywait=1 (any state):
     - All five write enables 0; all flush/bubble outputs 0.
     - pending_bubble is set if bubble_enable=1, and holds its value otherwise.
     - Next state FREEZE. branch_taken is ignored, since EX is frozen and it re-presents.
  2. branch_taken=1:
     - if_id_flush=1, id_ex_flush=1, all write enables 1.
     - Any bubble request (live or pending) is discarded; pending_bubble cleared.
     - flush_count++. Next state FLUSH_GUARD.
  3. Effective bubble request (bubble_enable OR pending_bubble) in RUN or FREEZE:
     - pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; EX/MEM and MEM/WB enables 1.
     - pending_bubble cleared; bubble_count++. Next state BUBBLE_GUARD.
  4. imem_busywait=1:
     - pc_write_en=0, if_id_flush=1; all other write enables 1.
     - Next state RUN.
  5. Otherwise: all write enables 1, flushes/bubbles 0, next state RUN.
- BUBBLE_GUARD and FLUSH_GUARD:
  - bubble_enable is ignored for that one cycle. The hazard unit's level still reflects the pre-bubble comparison, or a flushed instruction.
  - Priorities 1, 2, 4 and 5 still apply.
  - Next state is RUN, unless another transition fires.
- FREEZE exits when dmem_busywait falls. That cycle is evaluated with the normal priority, so a pending bubble fires on the first unfrozen cycle.
- Counters:
  - stall_cycles increments every cycle with pc_write_en=0.
  - All counters saturate at 2^CNT_W−1 and never wrap.
  - counter_clear=1 zeroes them at the next edge and overrides any increment in that same cycle.

Test Plan:
1. Reset asserted mid-FREEZE with pending_bubble=1 → outputs go to defaults immediately (async); after release a lone cycle produces no bubble, and all counters read 0.
2. bubble_enable high for 2 consecutive cycles in RUN → cycle 1: pc_write_en=0, id_ex_bubble=1; cycle 2 (BUBBLE_GUARD): all enables 1, no bubble; bubble_count=1, stall_cycles=1.
3. bubble_enable=1 for one cycle while dmem_busywait=1 for 3 cycles → 3 frozen cycles with all enables 0, then a bubble on cycle 4; bubble_count=1, stall_cycles=4.
4. branch_taken=1 with bubble_enable=1 in the same cycle → if_id_flush=id_ex_flush=1, id_ex_bubble=0; next cycle bubble_enable=1 is ignored; flush_count=1, bubble_count=0.
5. imem_busywait=1 for 2 cycles → pc_write_en=0 and if_id_flush=1 on both cycles, ex_mem_write_en=1 throughout; stall_cycles=2.
6. CNT_W=4, 20 bubble events → bubble_count=15; pulse counter_clear during an event cycle → bubble_count=0.

Source files
------------

// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the hazard/ALU/memory side and the stall controller.
// master: drives hazard, redirect, busywait and counter_clear; observes controls/counters.
// slave : the stall controller itself.
interface pipeline_stall_controller_if #(parameter int CNT_W = 16);
    logic             bubble_enable;
    logic             branch_taken;
    logic             imem_busywait;
    logic             dmem_busywait;
    logic             counter_clear;
    logic             pc_write_en;
    logic             if_id_write_en;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             id_ex_flush;
    logic             ex_mem_write_en;
    logic             mem_wb_write_en;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] bubble_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output bubble_enable, branch_taken, imem_busywait, dmem_busywait, counter_clear,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, id_ex_flush,
               ex_mem_write_en, mem_wb_write_en, stall_cycles, bubble_count, flush_count
    );

    modport slave (
        input  bubble_enable, branch_taken, imem_busywait, dmem_busywait, counter_clear,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, id_ex_flush,
               ex_mem_write_en, mem_wb_write_en, stall_cycles, bubble_count, flush_count
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller for a 5-stage RISC-V pipeline.
// Turns load-use bubble requests, ALU redirects and memory busywaits into per-stage
// write-enable / bubble / flush controls (combinational, same-cycle) and keeps
// saturating stall/bubble/flush counters.
// Ports: clk, reset (async, active high), bus (slave modport): inputs bubble_enable,
// branch_taken, imem_busywait, dmem_busywait, counter_clear; outputs the five
// stage controls plus stall_cycles, bubble_count, flush_count.
module pipeline_stall_controller #(
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic reset,
    pipeline_stall_controller_if.slave bus
);

    typedef enum logic [1:0] {RUN, FREEZE, BUBBLE_GUARD, FLUSH_GUARD} state_t;

    state_t     state, state_n;
    logic       pending_bubble, pending_n;
    logic       pc_we, ifid_we, ifid_fl, idex_bub, idex_fl, exmem_we, memwb_we;
    logic       inc_bubble, inc_flush;
    logic       guard;
    logic [CNT_W-1:0] stall_q, bubble_q, flush_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            pending_bubble <= 1'b0;
        end else begin
            state          <= state_n;
            pending_bubble <= pending_n;
        end
    end

    // The hazard unit's level is stale for one cycle after a bubble or flush.
    assign guard = (state == BUBBLE_GUARD) || (state == FLUSH_GUARD);

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_fl    = 1'b0;
        idex_bub   = 1'b0;
        idex_fl    = 1'b0;
        exmem_we   = 1'b1;
        memwb_we   = 1'b1;
        state_n    = RUN;
        pending_n  = pending_bubble;
        inc_bubble = 1'b0;
        inc_flush  = 1'b0;
        if (!reset) begin
            if (bus.dmem_busywait) begin
                // Whole pipe frozen; a bubble seen now is remembered and fires on exit.
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                exmem_we  = 1'b0;
                memwb_we  = 1'b0;
                pending_n = pending_bubble | (bus.bubble_enable & ~guard);
                state_n   = FREEZE;
            end else if (bus.branch_taken) begin
                ifid_fl   = 1'b1;
                idex_fl   = 1'b1;
                pending_n = 1'b0;
                inc_flush = 1'b1;
                state_n   = FLUSH_GUARD;
            end else if (!guard && (bus.bubble_enable || pending_bubble)) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_bub   = 1'b1;
                pending_n  = 1'b0;
                inc_bubble = 1'b1;
                state_n    = BUBBLE_GUARD;
            end else if (bus.imem_busywait) begin
                pc_we   = 1'b0;
                ifid_fl = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else if (bus.counter_clear) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            stall_q  <= sat_inc(stall_q, ~pc_we);
            bubble_q <= sat_inc(bubble_q, inc_bubble);
            flush_q  <= sat_inc(flush_q, inc_flush);
        end
    end

    assign bus.pc_write_en     = pc_we;
    assign bus.if_id_write_en  = ifid_we;
    assign bus.if_id_flush     = ifid_fl;
    assign bus.id_ex_bubble    = idex_bub;
    assign bus.id_ex_flush     = idex_fl;
    assign bus.ex_mem_write_en = exmem_we;
    assign bus.mem_wb_write_en = memwb_we;
    assign bus.stall_cycles    = stall_q;
    assign bus.bubble_count    = bubble_q;
    assign bus.flush_count     = flush_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller (CNT_W=4 so saturation is reachable).
module tb_pipeline_stall_controller;
    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pipeline_stall_controller_if #(.CNT_W(W)) bus ();
    pipeline_stall_controller #(.CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Reference: "ignore" = hazard level is stale this cycle (previous cycle bubbled
    // or flushed); "pend" = a bubble seen while memory was frozen.
    bit ignore_be, pend;
    int m_stall, m_bub, m_fl;
    logic [6:0] exp_ctrl; // {pc, ifid_we, ifid_fl, idex_bub, idex_fl, exmem, memwb}
    bit nxt_ignore, nxt_pend, do_bub, do_fl;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int sat(input int v, input bit inc);
        return (inc && v < MAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        ignore_be = 0; pend = 0; m_stall = 0; m_bub = 0; m_fl = 0;
    endtask

    task automatic predict();
        nxt_ignore = 0; nxt_pend = pend; do_bub = 0; do_fl = 0;
        if (bus.dmem_busywait) begin
            exp_ctrl = 7'b0000000;
            if (bus.bubble_enable && !ignore_be) nxt_pend = 1;
        end else if (bus.branch_taken) begin
            exp_ctrl = 7'b1110111;
            nxt_pend = 0; do_fl = 1; nxt_ignore = 1;
        end else if (pend || (bus.bubble_enable && !ignore_be)) begin
            exp_ctrl = 7'b0001011;
            nxt_pend = 0; do_bub = 1; nxt_ignore = 1;
        end else if (bus.imem_busywait) begin
            exp_ctrl = 7'b0110011;
        end else begin
            exp_ctrl = 7'b1100011;
        end
    endtask

    function automatic logic [6:0] dut_ctrl();
        return {bus.pc_write_en, bus.if_id_write_en, bus.if_id_flush, bus.id_ex_bubble,
                bus.id_ex_flush, bus.ex_mem_write_en, bus.mem_wb_write_en};
    endfunction

    // One clock: apply inputs, check controls mid-cycle, advance model, check counters.
    task automatic step(input string tag, input bit be, input bit br, input bit im,
                        input bit dm, input bit clr);
        bus.bubble_enable = be; bus.branch_taken = br; bus.imem_busywait = im;
        bus.dmem_busywait = dm; bus.counter_clear = clr;
        #2;
        predict();
        chk({tag, ".ctrl"}, int'(dut_ctrl()), int'(exp_ctrl));
        @(posedge clk); #1;
        if (clr) begin
            m_stall = 0; m_bub = 0; m_fl = 0;
        end else begin
            m_stall = sat(m_stall, !exp_ctrl[6]);
            m_bub   = sat(m_bub, do_bub);
            m_fl    = sat(m_fl, do_fl);
        end
        ignore_be = nxt_ignore; pend = nxt_pend;
        chk({tag, ".stall"}, int'(bus.stall_cycles), m_stall);
        chk({tag, ".bub"},   int'(bus.bubble_count), m_bub);
        chk({tag, ".flush"}, int'(bus.flush_count),  m_fl);
    endtask

    initial begin
        bus.bubble_enable = 0; bus.branch_taken = 0; bus.imem_busywait = 0;
        bus.dmem_busywait = 0; bus.counter_clear = 0;
        reset = 1;
        model_reset();
        #2;
        chk("rst.ctrl", int'(dut_ctrl()), 7'b1100011);
        @(posedge clk); #1;
        reset = 0;
        chk("rst.stall", int'(bus.stall_cycles), 0);
        chk("rst.bub",   int'(bus.bubble_count), 0);
        chk("rst.flush", int'(bus.flush_count),  0);

        // 1: reset mid-freeze with a pending bubble
        step("t1a", 1, 0, 0, 1, 0);
        step("t1b", 0, 0, 0, 1, 0);
        bus.dmem_busywait = 1; bus.bubble_enable = 1;
        #2; reset = 1; #1;
        chk("t1.async", int'(dut_ctrl()), 7'b1100011);
        @(posedge clk); #1;
        reset = 0; model_reset();
        step("t1c", 0, 0, 0, 0, 0);
        chk("t1.nobub", int'(bus.bubble_count), 0);
        chk("t1.stall0", int'(bus.stall_cycles), 0);

        // 2: two-cycle bubble_enable gives a single bubble
        step("t2a", 1, 0, 0, 0, 0);
        step("t2b", 1, 0, 0, 0, 0);
        chk("t2.bub", int'(bus.bubble_count), 1);
        chk("t2.stall", int'(bus.stall_cycles), 1);
        step("clr2", 0, 0, 0, 0, 1);

        // 3: bubble during a 3-cycle data freeze fires on the first unfrozen cycle
        step("t3a", 1, 0, 0, 1, 0);
        step("t3b", 0, 0, 0, 1, 0);
        step("t3c", 0, 0, 0, 1, 0);
        step("t3d", 0, 0, 0, 0, 0);
        chk("t3.idex_bub_seen", int'(bus.bubble_count), 1);
        chk("t3.stall", int'(bus.stall_cycles), 4);
        step("clr3", 0, 0, 0, 0, 1);

        // 4: redirect beats a bubble; next-cycle bubble level is ignored
        step("t4a", 1, 1, 0, 0, 0);
        step("t4b", 1, 0, 0, 0, 0);
        chk("t4.flush", int'(bus.flush_count), 1);
        chk("t4.bub", int'(bus.bubble_count), 0);
        step("clr4", 0, 0, 0, 0, 1);

        // 5: instruction memory wait
        step("t5a", 0, 0, 1, 0, 0);
        step("t5b", 0, 0, 1, 0, 0);
        chk("t5.stall", int'(bus.stall_cycles), 2);
        step("clr5", 0, 0, 0, 0, 1);

        // 6: saturation, then clear during an event cycle
        for (int i = 0; i < 20; i++) begin
            step("t6ev", 1, 0, 0, 0, 0);
            step("t6gap", 0, 0, 0, 0, 0);
        end
        chk("t6.sat", int'(bus.bubble_count), MAX);
        step("t6clr", 1, 0, 0, 0, 1);
        chk("t6.clr", int'(bus.bubble_count), 0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step("rnd", bit'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 40) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
